// File: rtl/row_render_sched.sv
// Row render scheduler: walks X across one row, picks the highest-priority sprite layer,
// issues the ROM read and writes the colour ROM_LAT cycles later. Optional ROW_RENDER_SCHED_STATS_EN adds overrun_cnt.
module row_render_sched #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned ROM_LAT  = 1,
  parameter logic [3:0]  BG_INDEX = 4'h0
) (
  input  logic             Clk50,
  input  logic             Reset_n,
  input  logic             row_start,
  input  logic [9:0]       next_row,
  input  logic [3:0]       layer_hit,
  input  logic [3:0][17:0] layer_addr,
  input  logic [3:0][3:0]  rom_q,
  output logic [15:0]      rom_addr,
  output logic [9:0]       fetch_X,
  output logic [9:0]       write_X,
  output logic [9:0]       write_Y,
  output logic [3:0]       write_data,
  output logic             write_en,
  output logic             buffer_select,
  output logic             busy,
  output logic             overrun
`ifdef ROW_RENDER_SCHED_STATS_EN
  ,
  output logic [7:0]       overrun_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [9:0]  X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [1:0]  D_LAST    = 2'(ROM_LAT - 1);
  localparam logic [15:0] FILL_ADDR = 16'd20;
  localparam logic [9:0]  Y_MAX     = 10'd524;

  state_t state, state_nx;

  logic [9:0] x_cnt;
  logic [1:0] drain_cnt;
  logic       start_ok;
  logic       fetching;
  logic       x_last;
  logic       drain_last;
  logic       hit_any;
  logic       found;
  logic [1:0] sel;

  logic [ROM_LAT-1:0] pv;
  logic [ROM_LAT-1:0] pn;
  logic [9:0]         px [ROM_LAT];
  logic [1:0]         pb [ROM_LAT];

  assign start_ok   = row_start && (next_row <= Y_MAX);
  assign x_last     = (x_cnt == X_LAST);
  assign drain_last = (drain_cnt == D_LAST);
  assign fetch_X    = x_cnt;

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // A valid row_start wins over every other transition, including mid-row aborts.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      FETCH:   if (x_last) state_nx = DRAIN;
      DRAIN:   if (drain_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start_ok) state_nx = FETCH;
  end

  always_comb begin
    busy     = (state != IDLE);
    fetching = (state == FETCH);
  end

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      x_cnt         <= '0;
      drain_cnt     <= '0;
      write_Y       <= '0;
      buffer_select <= 1'b0;
      overrun       <= 1'b0;
    end else if (start_ok) begin
      x_cnt         <= '0;
      drain_cnt     <= '0;
      write_Y       <= next_row;
      buffer_select <= ~buffer_select;
      if (busy) overrun <= 1'b1;
    end else if (fetching) begin
      x_cnt     <= x_last ? '0 : x_cnt + 10'd1;
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 2'd1;
    end
  end

  always_comb begin
    hit_any = |layer_hit;
    found   = 1'b0;
    sel     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (layer_hit[i] && !found) begin
        sel   = 2'(i);
        found = 1'b1;
      end
    end
    rom_addr = (fetching && hit_any) ? layer_addr[sel][15:0] : FILL_ADDR;
  end

  // Bank/no-hit/X ride a ROM_LAT-deep pipe; a restart invalidates every in-flight slot.
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      pv <= '0;
      pn <= '1;
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        px[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= fetching && !start_ok;
      pn[0] <= !hit_any;
      px[0] <= x_cnt;
      pb[0] <= layer_addr[sel][17:16];
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        pv[i] <= pv[i-1] && !start_ok;
        pn[i] <= pn[i-1];
        px[i] <= px[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  always_comb begin
    write_en   = pv[ROM_LAT-1];
    write_X    = px[ROM_LAT-1];
    write_data = (pv[ROM_LAT-1] && !pn[ROM_LAT-1]) ? rom_q[pb[ROM_LAT-1]] : BG_INDEX;
  end

`ifdef ROW_RENDER_SCHED_STATS_EN
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n)
      overrun_cnt <= '0;
    else if (start_ok && busy && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule
